disk_plotter: RTL and testbench

Consumer end of the board's plot-request interface: accepts one-cycle cell draw requests (top-left pixel, 2-bit cell content), rasterises the 12×12 on-screen cell pixel by pixel, and drives the VGA adapter's write port. It sits between the board RAM's scan output and the VGA adapter, with a one-entry pending buffer so back-to-back cell requests are not lost while a cell is drawing.

---
 rtl/othello_pkg.sv | 31 +++
 rtl/cell_scan_counter.sv | 51 +++++
 rtl/disk_plotter.sv | 162 ++++++++++++++++
 tb/tb_disk_plotter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared constants and types for the Othello board display path: colours,
// cell-content codes, board geometry and the plot-request record.
package othello_pkg;

  localparam logic [2:0] GRID  = 3'b001;
  localparam logic [2:0] BOARD = 3'b010;
  localparam logic [2:0] DISK0 = 3'b000;
  localparam logic [2:0] DISK1 = 3'b111;

  localparam logic [1:0] SEL_EMPTY = 2'b00;
  localparam logic [1:0] SEL_SIDE0 = 2'b10;
  localparam logic [1:0] SEL_SIDE1 = 2'b11;

  localparam int CELL_DEFAULT  = 12;
  localparam int INSET_DEFAULT = 2;

  localparam int BOARD_ORIGIN = 9;
  localparam int BOARD_PITCH  = 13;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel;
  } plot_req_t;

  // Top-left screen pixel of board cell idx along either axis.
  function automatic logic [7:0] board_px(input logic [2:0] idx);
    return 8'(BOARD_ORIGIN + BOARD_PITCH * int'(idx));
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major raster counter over a CELL x CELL pixel square; start zeroes it,
// advance steps one pixel, last flags the final pixel of the square.
module cell_scan_counter #(
  parameter int CELL = 12,
  parameter int W    = $clog2(CELL)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start_i,
  input  logic         advance_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST = W'(CELL - 1);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/disk_plotter.sv
// Rasterises one board cell per request into the VGA adapter write port,
// with a single pending slot so a request arriving mid-cell is kept.
module disk_plotter
  import othello_pkg::*;
#(
  parameter int CELL  = CELL_DEFAULT,
  parameter int INSET = INSET_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] x_plot,
  input  logic [6:0] y_plot,
  input  logic [1:0] select,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int W = $clog2(CELL);
  localparam logic [W-1:0] LO = W'(INSET);
  localparam logic [W-1:0] HI = W'(CELL - 1 - INSET);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  plot_req_t  act_q, act_d;
  plot_req_t  pend_q, pend_d;
  logic       pv_q, pv_d;
  logic       ovr_q, ovr_d;

  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;
  logic       vga_plot_q, busy_q, done_q;

  plot_req_t  req_in;
  logic       start, advance, last;
  logic [W-1:0] row, col;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       in_disk;

  assign req_in  = {x_plot, y_plot, select};
  assign advance = (state_q == ST_DRAW);

  cell_scan_counter #(.CELL(CELL), .W(W)) u_scan (
    .clock     (clock),
    .resetn    (resetn),
    .start_i   (start),
    .advance_i (advance),
    .row_o     (row),
    .col_o     (col),
    .last_o    (last)
  );

  // The pending slot is freed in the same DONE cycle it is consumed, so a
  // strobe landing there refills it instead of being dropped.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          act_d   = req_in;
          start   = 1'b1;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (last) state_d = ST_DONE;
        if (enable) begin
          if (!pv_q) begin
            pend_d = req_in;
            pv_d   = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (pv_q) begin
          act_d   = pend_q;
          start   = 1'b1;
          state_d = ST_DRAW;
          pv_d    = enable;
          if (enable) pend_d = req_in;
        end else if (enable) begin
          act_d   = req_in;
          start   = 1'b1;
          state_d = ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pix_x   = act_q.x + {{(8-W){1'b0}}, col};
  assign pix_y   = act_q.y + {{(7-W){1'b0}}, row};
  assign in_disk = (row >= LO) && (row <= HI) && (col >= LO) && (col <= HI);

  always_comb begin
    pix_colour = BOARD;
    if (row == '0 || col == '0)     pix_colour = GRID;
    else if (act_q.sel[1] && in_disk) pix_colour = act_q.sel[0] ? DISK1 : DISK0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      pv_q         <= 1'b0;
      ovr_q        <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      ovr_q   <= ovr_d;
      // Pixel coordinates hold their last value whenever nothing is written.
      if (state_q == ST_DRAW) begin
        vga_x_q      <= pix_x;
        vga_y_q      <= pix_y;
        vga_colour_q <= pix_colour;
        vga_plot_q   <= 1'b1;
      end else begin
        vga_plot_q   <= 1'b0;
      end
      done_q <= (state_q == ST_DONE);
      busy_q <= (state_d != ST_IDLE) || pv_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_disk_plotter.sv
// Directed bench for disk_plotter: per-cell vector table plus hand-built
// sequences for pending/overrun handling and mid-cell reset.
module tb_disk_plotter;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] x_plot = '0;
  logic [6:0] y_plot = '0;
  logic [1:0] select = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done, overrun;

  disk_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .x_plot     (x_plot),
    .y_plot     (y_plot),
    .select     (select),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int cap_x[$], cap_y[$], cap_c[$], cap_cyc[$], done_cyc[$];

  always @(negedge clock) begin
    if (vga_plot === 1'b1) begin
      cap_x.push_back(int'(vga_x));
      cap_y.push_back(int'(vga_y));
      cap_c.push_back(int'(vga_colour));
      cap_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_caps();
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_cyc.delete(); done_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Strobe one request; e returns the index of the edge that samples it.
  task automatic do_req(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                        output int e);
    @(negedge clock);
    enable = 1'b1; x_plot = x; y_plot = y; select = s;
    @(posedge clock);
    #1;
    e = cyc;
    enable = 1'b0;
  endtask

  function automatic int find_colour(input int px, input int py);
    for (int i = 0; i < cap_x.size(); i++)
      if (cap_x[i] == px && cap_y[i] == py) return cap_c[i];
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel;
    int         px;
    int         py;
    int         colour;
  } vec_t;

  vec_t vt[13];

  initial begin
    int e, e2, e3, n_grid, n_d0, n_d1, n_brd;
    logic [7:0] lx;
    logic [6:0] ly;

    vt[0]  = '{8'd9,   7'd9,   2'b11, 9,   9,   1};
    vt[1]  = '{8'd9,   7'd9,   2'b11, 11,  11,  7};
    vt[2]  = '{8'd9,   7'd9,   2'b11, 18,  18,  7};
    vt[3]  = '{8'd9,   7'd9,   2'b11, 19,  19,  2};
    vt[4]  = '{8'd9,   7'd9,   2'b11, 10,  10,  2};
    vt[5]  = '{8'd22,  7'd35,  2'b00, 33,  46,  2};
    vt[6]  = '{8'd22,  7'd35,  2'b00, 22,  40,  1};
    vt[7]  = '{8'd22,  7'd35,  2'b01, 27,  40,  2};
    vt[8]  = '{8'd100, 7'd50,  2'b10, 102, 52,  0};
    vt[9]  = '{8'd100, 7'd50,  2'b10, 101, 52,  2};
    vt[10] = '{8'd250, 7'd120, 2'b11, 250, 120, 1};
    vt[11] = '{8'd250, 7'd120, 2'b11, 255, 127, 7};
    vt[12] = '{8'd250, 7'd120, 2'b11, 5,   3,   2};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    resetn = 1'b1;

    // Single-cell vectors
    for (int v = 0; v < 13; v++) begin
      clear_caps();
      do_req(vt[v].x, vt[v].y, vt[v].sel, e);
      check($sformatf("v%0d_busy_hi", v), int'(busy), 1);
      repeat (150) @(negedge clock);
      check($sformatf("v%0d_nplots", v), cap_x.size(), 144);
      check($sformatf("v%0d_first_cyc", v), qget(cap_cyc, 0), e + 1);
      check($sformatf("v%0d_last_cyc", v), qget(cap_cyc, 143), e + 144);
      check($sformatf("v%0d_ndone", v), done_cyc.size(), 1);
      check($sformatf("v%0d_done_cyc", v), qget(done_cyc, 0), e + 145);
      lx = vt[v].x + 8'd11;
      ly = vt[v].y + 7'd11;
      check($sformatf("v%0d_last_x", v), qget(cap_x, 143), int'(lx));
      check($sformatf("v%0d_last_y", v), qget(cap_y, 143), int'(ly));
      n_grid = 0; n_d0 = 0; n_d1 = 0; n_brd = 0;
      foreach (cap_c[i]) begin
        case (cap_c[i])
          1: n_grid++;
          0: n_d0++;
          7: n_d1++;
          2: n_brd++;
          default: ;
        endcase
      end
      check($sformatf("v%0d_n_grid", v), n_grid, 23);
      check($sformatf("v%0d_n_disk0", v), n_d0, (vt[v].sel == 2'b10) ? 64 : 0);
      check($sformatf("v%0d_n_disk1", v), n_d1, (vt[v].sel == 2'b11) ? 64 : 0);
      check($sformatf("v%0d_n_board", v), n_brd, vt[v].sel[1] ? 57 : 121);
      check($sformatf("v%0d_probe_%0d_%0d", v, vt[v].px, vt[v].py),
            find_colour(vt[v].px, vt[v].py), vt[v].colour);
      check($sformatf("v%0d_busy_lo", v), int'(busy), 0);
    end

    // Three strobes: second goes pending, third is dropped
    do_reset();
    clear_caps();
    do_req(8'd9, 7'd9, 2'b10, e);
    repeat (4) @(posedge clock);
    do_req(8'd22, 7'd9, 2'b11, e2);
    do_req(8'd35, 7'd9, 2'b01, e3);
    @(negedge clock);
    check("ovr_set", int'(overrun), 1);
    check("ovr_busy", int'(busy), 1);
    repeat (300) @(negedge clock);
    check("ovr_nplots", cap_x.size(), 288);
    check("ovr_cell2_cyc", qget(cap_cyc, 144), e + 146);
    check("ovr_cell2_x", qget(cap_x, 144), 22);
    check("ovr_ndone", done_cyc.size(), 2);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_busy_lo", int'(busy), 0);

    // Strobe in the DONE cycle while pending is full
    do_reset();
    clear_caps();
    check("dn_ovr_clear", int'(overrun), 0);
    do_req(8'd9, 7'd9, 2'b11, e);
    repeat (4) @(posedge clock);
    do_req(8'd22, 7'd9, 2'b10, e2);
    repeat (139) @(posedge clock);
    do_req(8'd35, 7'd9, 2'b11, e3);
    repeat (460) @(negedge clock);
    check("dn_nplots", cap_x.size(), 432);
    check("dn_cell2_cyc", qget(cap_cyc, 144), e + 146);
    check("dn_cell2_x", qget(cap_x, 144), 22);
    check("dn_cell3_x", qget(cap_x, 288), 35);
    check("dn_cell3_cyc", qget(cap_cyc, 288), e + 291);
    check("dn_ndone", done_cyc.size(), 3);
    check("dn_done0", qget(done_cyc, 0), e + 145);
    check("dn_done1", qget(done_cyc, 1), e + 290);
    check("dn_done2", qget(done_cyc, 2), e + 435);
    check("dn_overrun", int'(overrun), 0);

    // Reset mid-cell with a pending entry
    do_reset();
    clear_caps();
    do_req(8'd9, 7'd9, 2'b11, e);
    repeat (4) @(posedge clock);
    do_req(8'd22, 7'd9, 2'b10, e2);
    repeat (64) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("mr_plot", int'(vga_plot), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_done", int'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (300) @(negedge clock);
    check("mr_nplots", cap_x.size(), 69);
    check("mr_ndone", done_cyc.size(), 0);
    check("mr_busy_after", int'(busy), 0);
    check("mr_vga_x", int'(vga_x), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
